// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_fwft : single-clock FIFO, watermarks, sticky errors, FWFT option
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH       = 1 << ASIZE;
  localparam logic [ASIZE:0] c_depth     = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] c_afull_th  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] c_aempty_th = (ASIZE+1)'(AEMPTY_TH);
  localparam logic           c_afull_rst = (AFULL_TH == 0);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             w_wr_acc, w_rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still pops on winc&&rinc.
  assign w_wr_acc = winc && !wfull_q  && !flush;
  assign w_rd_acc = rinc && !rempty_q && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (w_wr_acc) wptr_d = wptr_q + ASIZE'(1);
      if (w_rd_acc) rptr_d = rptr_q + ASIZE'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + (ASIZE+1)'(1);
        2'b01:   count_d = count_q - (ASIZE+1)'(1);
        default: count_d = count_q;
      endcase
      if (winc && wfull_q)  ovf_d = 1'b1;
      if (rinc && rempty_q) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= c_afull_rst;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= (count_d == c_depth);
      rempty_q <= (count_d == '0);
      afull_q  <= (count_d >= c_afull_th);
      aempty_q <= (count_d <= c_aempty_th);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; emptiness is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem_q[wptr_q] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem_q[rptr_q];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rdata_q <= '0;
        else if (flush)    rdata_q <= '0;
        else if (w_rd_acc) rdata_q <= mem_q[rptr_q];
      end
      assign rdata = rdata_q;
    end
  endgenerate

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft : directed bench, standard and FWFT instances in lockstep
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata_s, rdata_f;
  logic       wfull_s, rempty_s, afull_s, aempty_s, ovf_s, unf_s;
  logic       wfull_f, rempty_f, afull_f, aempty_f, ovf_f, unf_f;
  logic [3:0] count_s, count_f;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .walmost_full(afull_s),
    .ralmost_empty(aempty_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_fwft #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .walmost_full(afull_f),
    .ralmost_empty(aempty_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full status snapshot of both instances; rdata of the FWFT copy is excluded (don't-care when empty).
  task automatic chk_status(input string tag, input int cnt, input bit ovf, input bit unf);
    chk({tag, ".count"},   {28'd0, count_s}, cnt);
    chk({tag, ".count_f"}, {28'd0, count_f}, cnt);
    chk({tag, ".rempty"},  {31'd0, rempty_s}, (cnt == 0));
    chk({tag, ".wfull"},   {31'd0, wfull_s},  (cnt == 8));
    chk({tag, ".aempty"},  {31'd0, aempty_s}, (cnt <= 1));
    chk({tag, ".afull"},   {31'd0, afull_s},  (cnt >= 6));
    chk({tag, ".ovf"},     {31'd0, ovf_s}, ovf);
    chk({tag, ".unf"},     {31'd0, unf_s}, unf);
    chk({tag, ".flags_f"}, {26'd0, wfull_f, rempty_f, afull_f, aempty_f, ovf_f, unf_f},
        {26'd0, wfull_s, rempty_s, afull_s, aempty_s, ovf_s, unf_s});
  endtask

  initial begin
    // Reset held with random traffic on the request lines.
    for (int i = 0; i < 4; i++) begin
      winc  = 1'($urandom_range(0, 1));
      rinc  = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      step();
      chk_status("reset", 0, 1'b0, 1'b0);
      chk("reset.rdata", {24'd0, rdata_s}, 32'h00);
    end
    winc = 1'b0; rinc = 1'b0;
    rst_n = 1'b1;
    step();
    chk_status("post_reset", 0, 1'b0, 1'b0);

    // Fill 0x11..0x88, then one overflowing write of 0x99.
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wdata = 8'((i + 1) * 8'h11);
      step();
      chk_status("fill", i + 1, 1'b0, 1'b0);
    end
    wdata = 8'h99;
    step();
    winc = 1'b0;
    chk_status("overflow", 8, 1'b1, 1'b0);
    chk("fill.head_f", {24'd0, rdata_f}, 32'h11);
    rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain.rdata", {24'd0, rdata_s}, (i + 1) * 32'h11);
      if (i < 7) chk("drain.head_f", {24'd0, rdata_f}, (i + 2) * 32'h11);
    end
    rinc = 1'b0;
    chk_status("drained", 0, 1'b1, 1'b0);

    // Wrap-around after a flush.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_status("flush1", 0, 1'b0, 1'b0);
    chk("flush1.rdata", {24'd0, rdata_s}, 32'h00);
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin wdata = 8'(8'h50 + i); step(); end
    winc = 1'b0; rinc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wrap5.rdata", {24'd0, rdata_s}, 32'h50 + i);
    end
    rinc = 1'b0; winc = 1'b1;
    for (int i = 0; i < 8; i++) begin wdata = 8'(8'hA0 + i); step(); end
    winc = 1'b0;
    chk_status("wrap_full", 8, 1'b0, 1'b0);
    rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wrap8.rdata", {24'd0, rdata_s}, 32'hA0 + i);
    end
    rinc = 1'b0;
    chk_status("wrap_end", 0, 1'b0, 1'b0);

    // Simultaneous traffic at count 4, then at empty and at full.
    winc = 1'b1;
    for (int i = 0; i < 4; i++) begin wdata = 8'(8'hB0 + i); step(); end
    rinc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata = 8'(8'hB4 + k);
      step();
      chk("sim4.count", {28'd0, count_s}, 32'd4);
      chk("sim4.rdata", {24'd0, rdata_s}, 32'hB0 + k);
    end
    winc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sim4_tail.rdata", {24'd0, rdata_s}, 32'hBA + k);
    end
    winc = 1'b1; rinc = 1'b1; wdata = 8'hC1;
    step();
    rinc = 1'b0;
    chk_status("sim_empty", 1, 1'b0, 1'b1);
    chk("sim_empty.head_f", {24'd0, rdata_f}, 32'hC1);
    for (int i = 0; i < 7; i++) begin wdata = 8'(8'hC2 + i); step(); end
    chk_status("refill_full", 8, 1'b0, 1'b1);
    rinc = 1'b1; wdata = 8'hEE;
    step();
    winc = 1'b0; rinc = 1'b0;
    chk_status("sim_full", 7, 1'b1, 1'b1);
    chk("sim_full.rdata", {24'd0, rdata_s}, 32'hC1);
    chk("sim_full.head_f", {24'd0, rdata_f}, 32'hC2);

    // FWFT head visibility.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_status("flush2", 0, 1'b0, 1'b0);
    winc = 1'b1; wdata = 8'hA5;
    step();
    winc = 1'b0;
    chk_status("fwft_wr", 1, 1'b0, 1'b0);
    chk("fwft_wr.rdata_f", {24'd0, rdata_f}, 32'hA5);
    chk("fwft_wr.rdata_s", {24'd0, rdata_s}, 32'h00);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk_status("fwft_rd", 0, 1'b0, 1'b0);
    chk("fwft_rd.rdata_s", {24'd0, rdata_s}, 32'hA5);

    // Flush with a concurrent write at count 5 with overflow set.
    winc = 1'b1;
    for (int i = 0; i < 9; i++) begin wdata = 8'(8'hD0 + i); step(); end
    winc = 1'b0; rinc = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rinc = 1'b0;
    chk_status("pre_flush", 5, 1'b1, 1'b0);
    chk("pre_flush.rdata", {24'd0, rdata_s}, 32'hD2);
    flush = 1'b1; winc = 1'b1; wdata = 8'h77;
    step();
    flush = 1'b0; winc = 1'b0;
    chk_status("flush3", 0, 1'b0, 1'b0);
    chk("flush3.rdata", {24'd0, rdata_s}, 32'h00);
    step();
    chk_status("flush3_drop", 0, 1'b0, 1'b0);

    // Asynchronous reset between edges with data in flight.
    winc = 1'b1;
    for (int i = 0; i < 4; i++) begin wdata = 8'(8'hE1 + i); step(); end
    winc = 1'b0; rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk_status("pre_reset", 3, 1'b0, 1'b0);
    chk("pre_reset.rdata", {24'd0, rdata_s}, 32'hE1);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async_reset", 0, 1'b0, 1'b0);
    chk("async_reset.rdata", {24'd0, rdata_s}, 32'h00);
    step();
    rst_n = 1'b1;
    step();
    chk_status("after_reset", 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable read mode: standard registered read, or first-word-fall-through (FWFT). It is the single-domain successor to the dual-clock FIFO. It is used wherever producer and consumer share one clock and need watermark-based flow control rather than only full/empty.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 3: address width; DEPTH = 1 << ASIZE entries.
- AFULL_TH, DEPTH-2: walmost_full asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 1: ralmost_empty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous clear of contents and error flags.
- winc, input, 1: write request.
- wdata, input, DSIZE: write data.
- rinc, input, 1: read request.
- rdata, output, DSIZE: read data.
- wfull, output, 1: count == DEPTH.
- rempty, output, 1: count == 0.
- walmost_full, output, 1: count >= AFULL_TH.
- ralmost_empty, output, 1: count <= AEMPTY_TH.
- count, output, ASIZE+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

## Operation
- Storage: DEPTH x DSIZE array. Write pointer and read pointer are ASIZE bits each and wrap modulo DEPTH. count is a separate ASIZE+1-bit register.
- Accepted write: winc && !wfull, evaluated on flag values before the edge. wdata is stored at wptr; wptr increments.
- Accepted read: rinc && !rempty. rptr increments.
- The full condition is checked before the edge: if winc && rinc while full, the read is accepted and the write is rejected. This counts as an overflow, and count becomes DEPTH-1.
- The empty condition is checked before the edge: if winc && rinc while empty, the write is accepted and the read is rejected. This counts as an underflow, and count becomes 1.
- When both are accepted, count is unchanged.
- count update: count_next = count + accepted write - accepted read. count never exceeds DEPTH and never goes below 0.
- overflow is set by winc && wfull. underflow is set by rinc && rempty. Each holds until flush or reset.
- FWFT=0: on an accepted read, rdata registers mem[rptr]. Otherwise rdata holds its last value.
- FWFT=1: rdata = mem[rptr] continuously; the head word is visible without rinc. rinc pops the head word. rdata is don't-care while rempty=1.
- flush overrides winc and rinc in the same cycle:
  - wptr, rptr and count go to 0.
  - overflow and underflow are cleared.
  - In FWFT=0, rdata is cleared to 0.
  - Memory contents are not cleared.
- Flags are registered and derived from count_next: wfull, rempty, walmost_full, ralmost_empty.

## Timing
- Reset values (rst_n low, asynchronous): count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=(AFULL_TH==0 ? 1 : 0), overflow=0, underflow=0, rdata=0.
- Reset can be asserted mid-operation. It takes effect immediately, regardless of clk, and drops all contents.
- Write-to-empty latency: after the write edge, rempty=0 and count=1 in the next cycle.
  - FWFT=1: rdata equals that word in the same cycle.
  - FWFT=0: rdata changes only after the rinc edge, becoming valid in the cycle after that edge.
- Full latency: wfull=1 in the cycle after the write that makes count=DEPTH. Exactly one cycle after the pop, wfull=0.
- Throughput: one write and one read per cycle, sustained at any occupancy strictly between 0 and DEPTH.
- No combinational path from winc or rinc to any output. In FWFT mode, rdata depends only on registered rptr and memory.

## Test plan
Configuration for all scenarios: DSIZE=8, ASIZE=3, AFULL_TH=6, AEMPTY_TH=1, unless noted.
1. Reset: hold rst_n=0 with random winc/rinc -> count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, overflow=0, underflow=0, rdata=0.
2. Fill and overflow: write 0x11,0x22,...,0x88, then 0x99 -> walmost_full=1 after the 6th write, wfull=1 and count=8 after the 8th, overflow=1 after the 9th attempt. Read 8 words -> rdata sequence 0x11..0x88, 0x99 never appears; rempty=1 and overflow still 1.
3. Wrap-around: write 5 words, read 5, then write 8 (0xA0..0xA7) and read 8 -> the data comes out in order 0xA0..0xA7 across the pointer wrap, and count ends at 0.
4. Simultaneous access: at count=4, assert winc and rinc for 10 cycles -> count stays 4 and data stays in order. At count=0, assert both for 1 cycle -> count=1, underflow=1. At count=8, assert both -> count=7, overflow=1.
5. FWFT=1: write 0xA5 into an empty FIFO -> the next cycle shows rempty=0 and rdata=0xA5 with rinc=0. Then pulse rinc -> rempty=1, count=0.
6. Flush and reset mid-stream:
   - At count=5 with overflow=1, pulse flush while winc=1 -> next cycle count=0, rempty=1, overflow=0, and the write is dropped.
   - Refill to 3, then drop rst_n between clock edges -> outputs reach their reset values immediately.
